// File: rtl/led_seq_pkg.sv
// Shared types and reset constants for the LED bar sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package led_seq_pkg;

    localparam int          WIDTH_C       = 16;
    localparam int          CNT_W_C       = 32;
    localparam logic [31:0] DEF_PERIOD_C  = 32'd5000000;
    localparam logic [15:0] DEF_PATTERN_C = 16'hD221;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_LOAD_PAT   = 3'd1,
        OP_SET_PERIOD = 3'd2,
        OP_START      = 3'd3,
        OP_STOP       = 3'd4,
        OP_STEP       = 3'd5,
        OP_SET_DIR    = 3'd6,
        OP_SET_MODE   = 3'd7
    } op_e;

    // Encoding 3 is kept distinct but behaves exactly like ROTATE.
    typedef enum logic [1:0] {
        MODE_ROTATE     = 2'd0,
        MODE_BOUNCE     = 2'd1,
        MODE_BLINK      = 2'd2,
        MODE_ROTATE_ALT = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SINGLE = 2'd2
    } state_e;

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Command port of the LED sequencer: opcode plus 32-bit argument.
// Latency: a command is taken on the edge where valid and ready are both high.
// Backpressure: ready drops while a single step is being applied; the host holds the command.
interface led_seq_ctrl_if;
    import led_seq_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    op_e         cmd_op;
    logic [31:0] cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/led_seq_prescaler.sv
// Step prescaler: counts 0..period and flags the terminal count as a tick.
// Latency: tick is combinational from the count register; interval is period+1 cycles.
// Backpressure: none; clr has priority over counting, count holds while en is low.
module led_seq_prescaler #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] count;

    assign tick = en && (count == period);

    // Count up while enabled, wrap to zero on the tick, restart on clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// Command-driven LED bar sequencer (rotate / bounce / blink) with run, stop and single-step.
// Latency: led and step_pulse update on the edge that ends the tick or SINGLE cycle.
// Backpressure: cmd_ready is low only in SINGLE; optional LED_SEQ_AUTOSTART_EN resets into RUN.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               CNT_W       = 32,
    parameter logic [CNT_W-1:0] DEF_PERIOD  = CNT_W'(DEF_PERIOD_C),
    parameter logic [WIDTH-1:0] DEF_PATTERN = WIDTH'(DEF_PATTERN_C)
) (
    input  logic             clk,
    input  logic             rst,
    led_seq_ctrl_if.slave    cmd,
    output logic [WIDTH-1:0] led,
    output logic             busy,
    output logic             step_pulse
);

    localparam int                 BSTEP_W = $clog2(WIDTH);
    localparam logic [BSTEP_W-1:0] BSTEP_LAST = BSTEP_W'(WIDTH - 2);

`ifdef LED_SEQ_AUTOSTART_EN
    localparam state_e RST_STATE = ST_RUN;
`else
    localparam state_e RST_STATE = ST_IDLE;
`endif

    state_e             state, state_nx;
    mode_e              mode, mode_nx;
    logic [WIDTH-1:0]   pattern, pattern_nx, rotated, led_nx;
    logic [CNT_W-1:0]   period, period_nx;
    logic [BSTEP_W-1:0] bstep, bstep_nx;
    logic               dir, dir_nx;
    logic               blank, blank_nx;
    logic               accept, cmd_blocks_step, step, cnt_clr, tick;

    assign cmd.cmd_ready = (state != ST_SINGLE);
    assign busy          = (state != ST_IDLE);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign rotated       = (dir == DIR_RIGHT) ? {pattern[0], pattern[WIDTH-1:1]}
                                              : {pattern[WIDTH-2:0], pattern[WIDTH-1]};

    led_seq_prescaler #(.CNT_W(CNT_W)) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en     (state == ST_RUN),
        .clr    (cnt_clr),
        .period (period),
        .tick   (tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_STATE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and datapath: apply a step, then let an accepted command override it.
    always_comb begin
        state_nx        = state;
        mode_nx         = mode;
        pattern_nx      = pattern;
        period_nx       = period;
        bstep_nx        = bstep;
        dir_nx          = dir;
        blank_nx        = blank;
        cnt_clr         = 1'b0;
        // Only NOP and STEP let a coincident tick through; every other command owns the cycle.
        cmd_blocks_step = accept && (cmd.cmd_op != OP_NOP) && (cmd.cmd_op != OP_STEP);
        step            = (state == ST_SINGLE) || (tick && !cmd_blocks_step);

        if (step) begin
            case (mode)
                MODE_BLINK: begin
                    blank_nx = ~blank;
                end
                MODE_BOUNCE: begin
                    pattern_nx = rotated;
                    if (bstep == BSTEP_LAST) begin
                        dir_nx   = ~dir;
                        bstep_nx = '0;
                    end else begin
                        bstep_nx = bstep + BSTEP_W'(1);
                    end
                end
                default: begin
                    pattern_nx = rotated;
                end
            endcase
        end

        if (state == ST_SINGLE) begin
            state_nx = ST_IDLE;
        end

        if (accept) begin
            case (cmd.cmd_op)
                OP_LOAD_PAT: begin
                    pattern_nx = cmd.cmd_data[WIDTH-1:0];
                    blank_nx   = 1'b0;
                    bstep_nx   = '0;
                end
                OP_SET_PERIOD: begin
                    period_nx = cmd.cmd_data[CNT_W-1:0];
                    cnt_clr   = 1'b1;
                end
                OP_START: begin
                    state_nx = ST_RUN;
                    cnt_clr  = 1'b1;
                end
                OP_STOP: begin
                    state_nx = ST_IDLE;
                    cnt_clr  = 1'b1;
                    blank_nx = 1'b0;
                end
                OP_STEP: begin
                    if (state == ST_IDLE) begin
                        state_nx = ST_SINGLE;
                    end
                end
                OP_SET_DIR: begin
                    dir_nx = cmd.cmd_data[0];
                end
                OP_SET_MODE: begin
                    mode_nx  = mode_e'(cmd.cmd_data[1:0]);
                    bstep_nx = '0;
                    blank_nx = 1'b0;
                end
                default: begin
                end
            endcase
        end

        led_nx = blank_nx ? '0 : pattern_nx;
    end

    // Datapath registers; led is registered from the post-step/post-command view.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern    <= DEF_PATTERN;
            period     <= DEF_PERIOD;
            mode       <= MODE_ROTATE;
            dir        <= DIR_LEFT;
            blank      <= 1'b0;
            bstep      <= '0;
            led        <= DEF_PATTERN;
            step_pulse <= 1'b0;
        end else begin
            pattern    <= pattern_nx;
            period     <= period_nx;
            mode       <= mode_nx;
            dir        <= dir_nx;
            blank      <= blank_nx;
            bstep      <= bstep_nx;
            led        <= led_nx;
            step_pulse <= step;
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: directed walk-through plus randomized commands against a behavioural model.
// Latency: model advances on each rising edge; outputs compared on each falling edge.
// Backpressure: command driver holds valid until the DUT shows ready.
module tb_led_seq_ctrl;
    import led_seq_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] led;
    logic        busy;
    logic        step_pulse;

    led_seq_ctrl_if bus ();

    led_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (bus),
        .led        (led),
        .busy       (busy),
        .step_pulse (step_pulse)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: run flag, single-step flag, sweep counter.
    bit          m_on = 0;
    bit          m_run, m_single;
    bit [15:0]   m_pat;
    bit          m_blank, m_dir;
    int          m_mode, m_sweep;
    longint      m_cnt, m_per;
    bit [15:0]   m_led;
    bit          m_pulse;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit [15:0] rot(input bit [15:0] p, input bit right);
        bit [16:0] t;
        if (right) begin
            t = {1'b0, p} >> 1;
            return t[15:0] | (p[0] ? 16'h8000 : 16'h0000);
        end
        t = {p, 1'b0};
        return t[15:0] | {15'd0, t[16]};
    endfunction

    task automatic model_reset();
`ifdef LED_SEQ_AUTOSTART_EN
        m_run = 1;
`else
        m_run = 0;
`endif
        m_single = 0;
        m_pat = 16'hD221; m_blank = 0; m_dir = 0; m_mode = 0; m_sweep = 0;
        m_cnt = 0; m_per = 5000000;
        m_led = 16'hD221; m_pulse = 0;
    endtask

    task automatic model_edge();
        bit acc, tick, stp;
        int op;
        logic [31:0] d;
        if (rst) begin
            model_reset();
            m_on = 1;
            return;
        end
        if (!m_on) return;
        acc  = (bus.cmd_valid === 1'b1) && !m_single;
        op   = int'(bus.cmd_op);
        d    = bus.cmd_data;
        tick = m_run && (m_cnt == m_per);
        if (m_run) m_cnt = tick ? 0 : m_cnt + 1;
        stp  = m_single || (tick && !(acc && op != 0 && op != 5));
        if (stp) begin
            if (m_mode == 2) begin
                m_blank = !m_blank;
            end else begin
                m_pat = rot(m_pat, m_dir);
                if (m_mode == 1) begin
                    m_sweep++;
                    if (m_sweep == 15) begin
                        m_sweep = 0;
                        m_dir = !m_dir;
                    end
                end
            end
        end
        m_single = 0;
        if (acc) begin
            case (op)
                1: begin m_pat = d[15:0]; m_blank = 0; m_sweep = 0; end
                2: begin m_per = longint'(d); m_cnt = 0; end
                3: begin m_run = 1; m_cnt = 0; end
                4: begin m_run = 0; m_cnt = 0; m_blank = 0; end
                5: if (!m_run && !stp) m_single = 1;
                6: m_dir = d[0];
                7: begin m_mode = (d[1:0] == 2'd3) ? 0 : int'(d[1:0]); m_sweep = 0; m_blank = 0; end
                default: ;
            endcase
        end
        m_led   = m_blank ? 16'h0000 : m_pat;
        m_pulse = stp;
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    // Per-cycle compare against the model.
    initial forever begin
        @(negedge clk);
        if (m_on) begin
            chk("led", led, m_led);
            chk("busy", busy, m_run || m_single);
            chk("step_pulse", step_pulse, m_pulse);
            chk("cmd_ready", bus.cmd_ready, !m_single);
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [2:0] op, input logic [31:0] d);
        bit acc;
        int waitc;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op_e'(op);
        bus.cmd_data  = d;
        waitc = 0;
        forever begin
            acc = (bus.cmd_ready === 1'b1);
            @(posedge clk);
            @(negedge clk);
            if (acc) break;
            waitc++;
            if (waitc > 8) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: op %0d still not accepted after %0d cycles", op, waitc);
                break;
            end
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        bus.cmd_data  = '0;
        idle(3);
        rst = 1'b0;
        chk("reset_led", led, 16'hD221);
`ifdef LED_SEQ_AUTOSTART_EN
        chk("reset_busy", busy, 1'b1);
`else
        chk("reset_busy", busy, 1'b0);
`endif
        chk("reset_pulse", step_pulse, 1'b0);
        chk("reset_ready", bus.cmd_ready, 1'b1);

        // Rotate left at period 3: a step every 4 cycles.
        send(3'd2, 32'd3);
        send(3'd3, 32'd0);
        idle(4);
        chk("rot1_led", led, 16'hA443);
        chk("rot1_pulse", step_pulse, 1'b1);
        idle(4);
        chk("rot2_led", led, 16'h4887);

        // Rotate right every cycle, then freeze on STOP.
        send(3'd4, 32'd0);
        send(3'd1, 32'h0001);
        send(3'd6, 32'd1);
        send(3'd2, 32'd0);
        send(3'd3, 32'd0);
        idle(1);
        chk("right1_led", led, 16'h8000);
        idle(1);
        chk("right2_led", led, 16'h4000);
        send(3'd4, 32'd0);
        chk("stop_led", led, 16'h4000);
        chk("stop_busy", busy, 1'b0);
        idle(3);
        chk("stop_frozen", led, 16'h4000);

        // Single steps with a stalled second STEP.
        send(3'd1, 32'h0003);
        send(3'd6, 32'd0);
        send(3'd5, 32'd0);
        chk("single_ready_low", bus.cmd_ready, 1'b0);
        send(3'd5, 32'd0);
        chk("single1_led", led, 16'h0006);
        idle(1);
        chk("single2_led", led, 16'h000C);
        chk("single2_pulse", step_pulse, 1'b1);

        // Bounce: 15 steps out, 15 back.
        send(3'd7, 32'd1);
        send(3'd6, 32'd0);
        send(3'd1, 32'h0001);
        send(3'd2, 32'd0);
        send(3'd3, 32'd0);
        idle(15);
        chk("bounce_top", led, 16'h8000);
        idle(15);
        chk("bounce_back", led, 16'h0001);
        send(3'd4, 32'd0);

        // Blink at period 1.
        send(3'd7, 32'd2);
        send(3'd1, 32'h00FF);
        send(3'd2, 32'd1);
        send(3'd3, 32'd0);
        idle(2);
        chk("blink_off", led, 16'h0000);
        idle(2);
        chk("blink_on", led, 16'h00FF);
        idle(2);
        chk("blink_off2", led, 16'h0000);
        send(3'd4, 32'd0);
        chk("blink_stop", led, 16'h00FF);

        // LOAD_PAT landing exactly on the tick edge.
        send(3'd7, 32'd0);
        send(3'd6, 32'd0);
        send(3'd2, 32'd3);
        send(3'd3, 32'd0);
        idle(3);
        send(3'd1, 32'h1234);
        chk("collide_led", led, 16'h1234);
        chk("collide_pulse", step_pulse, 1'b0);
        idle(6);

        // Reset while running.
        rst = 1'b1;
        idle(1);
        chk("midrst_led", led, 16'hD221);
`ifdef LED_SEQ_AUTOSTART_EN
        chk("midrst_busy", busy, 1'b1);
`else
        chk("midrst_busy", busy, 1'b0);
`endif
        rst = 1'b0;

        // Randomized command stream.
        send(3'd2, 32'd1);
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  op;
            logic [31:0] d;
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
                send(3'd2, 32'($urandom_range(0, 3)));
            end
            op = 3'($urandom_range(0, 7));
            case (op)
                3'd2:    d = 32'($urandom_range(0, 4));
                3'd7:    d = 32'($urandom_range(0, 3));
                default: d = $urandom;
            endcase
            send(op, d);
            idle($urandom_range(0, 3));
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: bench still running at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
